// File: rtl/mem_dpi_pkg.sv
// Shared types, constants and the backing-store model for the two-channel memory port.
// The memory model implements the readInsData/readMemData/writeMemData call interface.
// It is byte addressed and little-endian. Locations that were never written read as zero.
package mem_dpi_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    typedef enum logic {CH_INST = 1'b0, CH_LSU = 1'b1} chan_t;

    localparam logic [7:0] LEN_B = 8'd1;
    localparam logic [7:0] LEN_H = 8'd2;
    localparam logic [7:0] LEN_W = 8'd4;
    localparam logic [7:0] LEN_D = 8'd8;

    logic [7:0]  mem_bytes [logic [63:0]];
    int unsigned dpi_calls;

    // Only byte, half, word and double accesses reach the backing store.
    function automatic logic len_legal(input logic [7:0] len);
        return (len == LEN_B) || (len == LEN_H) || (len == LEN_W) || (len == LEN_D);
    endfunction

    function automatic logic [63:0] readMemData(input logic [63:0] addr, input logic [7:0] len);
        logic [63:0] r;
        r = '0;
        dpi_calls++;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(len) && mem_bytes.exists(addr + 64'(i)))
                r[8*i +: 8] = mem_bytes[addr + 64'(i)];
        end
        return r;
    endfunction

    function automatic logic [31:0] readInsData(input logic [63:0] addr, input logic [7:0] len);
        logic [31:0] r;
        r = '0;
        dpi_calls++;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(len) && mem_bytes.exists(addr + 64'(i)))
                r[8*i +: 8] = mem_bytes[addr + 64'(i)];
        end
        return r;
    endfunction

    function automatic void writeMemData(input logic [63:0] addr, input logic [63:0] data,
                                         input logic [7:0] len);
        dpi_calls++;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(len))
                mem_bytes[addr + 64'(i)] = data[8*i +: 8];
        end
    endfunction

endpackage

// File: rtl/mem_dpi_arb.sv
// Two-way request arbiter for the memory port. Bit 0 is the fetch channel and bit 1 is the LSU channel.
// With MEM_DPI_RR_ARB_EN defined, the channel not served last wins a tie.
// Without it, LSU has fixed priority over fetch and no pointer register is built.
module mem_dpi_arb
    import mem_dpi_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

`ifdef MEM_DPI_RR_ARB_EN
    chan_t prio_q;

    // After every accept, the channel that was not just served gets the preference for the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prio_q <= CH_INST;
        else if (accept)
            prio_q <= grant[1] ? CH_INST : CH_LSU;
    end

    // A tie goes to the preferred channel. A lone valid is granted directly.
    always_comb begin
        grant = valid;
        if (valid == 2'b11)
            grant = (prio_q == CH_LSU) ? 2'b10 : 2'b01;
    end
`else
    logic unused_arb;
    assign unused_arb = ^{clk, rst_n, accept};

    // LSU always beats fetch when both are requesting.
    always_comb begin
        grant = valid;
        if (valid[1])
            grant = 2'b10;
    end
`endif

endmodule

// File: rtl/mem_dpi_arb_port.sv
// Two-channel memory port: instruction fetch and load/store share one backing store.
// Only one transaction is in flight at a time.
// The response appears LAT cycles after the request is accepted.
// Build option: MEM_DPI_RR_ARB_EN selects round-robin arbitration instead of LSU-first.
module mem_dpi_arb_port
    import mem_dpi_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int INST_W = 32,
    parameter int LAT    = 2
)
(
    input  logic              iClock,
    input  logic              iResetN,
    input  logic              iInstReqValid,
    output logic              oInstReqReady,
    input  logic [ADDR_W-1:0] iInstReqAddr,
    output logic              oInstRespValid,
    input  logic              iInstRespReady,
    output logic [INST_W-1:0] oInstRespData,
    output logic              oInstRespErr,
    input  logic              iLsuReqValid,
    output logic              oLsuReqReady,
    input  logic              iLsuReqWe,
    input  logic [ADDR_W-1:0] iLsuReqAddr,
    input  logic [DATA_W-1:0] iLsuReqData,
    input  logic [7:0]        iLsuReqLen,
    output logic              oLsuRespValid,
    input  logic              iLsuRespReady,
    output logic [DATA_W-1:0] oLsuRespData,
    output logic              oLsuRespErr,
    output logic              oBusy
);

    localparam int CNT_W = $clog2(LAT + 1);

    state_t            state_q;
    chan_t             ch_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [7:0]        len_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [1:0] arb_valid;
    logic [1:0] grant;
    logic       accept;
    logic       resp_ready;

    // Requests are only offered to the arbiter while idle and out of reset, so the readies drop everywhere else.
    assign arb_valid = (state_q == IDLE && iResetN) ? {iLsuReqValid, iInstReqValid} : 2'b00;

    mem_dpi_arb u_arb (
        .clk    (iClock),
        .rst_n  (iResetN),
        .valid  (arb_valid),
        .accept (accept),
        .grant  (grant)
    );

    assign oInstReqReady = grant[0];
    assign oLsuReqReady  = grant[1];
    assign accept        = |grant;
    assign resp_ready    = (ch_q == CH_LSU) ? iLsuRespReady : iInstRespReady;
    assign oBusy         = (state_q != IDLE);

    // The transaction FSM works as follows.
    // It latches the request when it is accepted.
    // It counts down the latency and performs the memory access on the last waiting edge.
    // It then holds the response until the core takes it.
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            state_q        <= IDLE;
            ch_q           <= CH_INST;
            we_q           <= 1'b0;
            addr_q         <= '0;
            data_q         <= '0;
            len_q          <= '0;
            cnt_q          <= '0;
            oInstRespValid <= 1'b0;
            oInstRespData  <= '0;
            oInstRespErr   <= 1'b0;
            oLsuRespValid  <= 1'b0;
            oLsuRespData   <= '0;
            oLsuRespErr    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        ch_q    <= grant[1] ? CH_LSU : CH_INST;
                        we_q    <= grant[1] & iLsuReqWe;
                        addr_q  <= grant[1] ? iLsuReqAddr : iInstReqAddr;
                        data_q  <= iLsuReqData;
                        len_q   <= grant[1] ? iLsuReqLen : LEN_W;
                        cnt_q   <= CNT_W'(LAT);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= RESP;
                        if (ch_q == CH_INST) begin
                            oInstRespValid <= 1'b1;
                            if (addr_q[1:0] != 2'b00) begin
                                oInstRespData <= '0;
                                oInstRespErr  <= 1'b1;
                            end else begin
                                oInstRespData <= INST_W'(readInsData(64'(addr_q), LEN_W));
                                oInstRespErr  <= 1'b0;
                            end
                        end else begin
                            oLsuRespValid <= 1'b1;
                            if (!len_legal(len_q)) begin
                                oLsuRespData <= '0;
                                oLsuRespErr  <= 1'b1;
                            end else if (we_q) begin
                                writeMemData(64'(addr_q), 64'(data_q), len_q);
                                oLsuRespData <= '0;
                                oLsuRespErr  <= 1'b0;
                            end else begin
                                oLsuRespData <= DATA_W'(readMemData(64'(addr_q), len_q));
                                oLsuRespErr  <= 1'b0;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        oInstRespValid <= 1'b0;
                        oLsuRespValid  <= 1'b0;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dpi_arb_port.sv
// Self-checking bench for mem_dpi_arb_port.
// It uses directed and randomized transactions and checks them against a byte-level memory model.
module tb_mem_dpi_arb_port;

    localparam int LAT = 2;

    logic        iClock = 1'b0;
    logic        iResetN;
    logic        iInstReqValid;
    logic        oInstReqReady;
    logic [63:0] iInstReqAddr;
    logic        oInstRespValid;
    logic        iInstRespReady;
    logic [31:0] oInstRespData;
    logic        oInstRespErr;
    logic        iLsuReqValid;
    logic        oLsuReqReady;
    logic        iLsuReqWe;
    logic [63:0] iLsuReqAddr;
    logic [63:0] iLsuReqData;
    logic [7:0]  iLsuReqLen;
    logic        oLsuRespValid;
    logic        iLsuRespReady;
    logic [63:0] oLsuRespData;
    logic        oLsuRespErr;
    logic        oBusy;

    int          checks = 0;
    int          errors = 0;
    int unsigned ref_calls = 0;
    bit          rr_pref = 1'b0;
    logic [7:0]  ref_mem [logic [63:0]];

    mem_dpi_arb_port #(.ADDR_W(64), .DATA_W(64), .INST_W(32), .LAT(LAT)) dut (
        .iClock         (iClock),
        .iResetN        (iResetN),
        .iInstReqValid  (iInstReqValid),
        .oInstReqReady  (oInstReqReady),
        .iInstReqAddr   (iInstReqAddr),
        .oInstRespValid (oInstRespValid),
        .iInstRespReady (iInstRespReady),
        .oInstRespData  (oInstRespData),
        .oInstRespErr   (oInstRespErr),
        .iLsuReqValid   (iLsuReqValid),
        .oLsuReqReady   (oLsuReqReady),
        .iLsuReqWe      (iLsuReqWe),
        .iLsuReqAddr    (iLsuReqAddr),
        .iLsuReqData    (iLsuReqData),
        .iLsuReqLen     (iLsuReqLen),
        .oLsuRespValid  (oLsuRespValid),
        .iLsuRespReady  (iLsuRespReady),
        .oLsuRespData   (oLsuRespData),
        .oLsuRespErr    (oLsuRespErr),
        .oBusy          (oBusy)
    );

    always #5 iClock = ~iClock;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    function automatic logic [63:0] ref_read(input logic [63:0] addr, input int len);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < len; i++)
            if (ref_mem.exists(addr + 64'(i))) r[8*i +: 8] = ref_mem[addr + 64'(i)];
        return r;
    endfunction

    function automatic void ref_write(input logic [63:0] addr, input logic [63:0] data, input int len);
        for (int i = 0; i < len; i++) ref_mem[addr + 64'(i)] = data[8*i +: 8];
    endfunction

    // One complete transaction on one channel, entered and left in IDLE just after a rising edge.
    task automatic run_txn(input bit lsu, input bit we, input logic [63:0] addr,
                           input logic [63:0] data, input logic [7:0] len, input int hold);
        logic [63:0] exp_data;
        bit          exp_err;
        exp_data = '0;
        exp_err  = 1'b0;
        if (lsu) begin
            iLsuReqValid = 1'b1; iLsuReqWe = we; iLsuReqAddr = addr;
            iLsuReqData = data; iLsuReqLen = len;
        end else begin
            iInstReqValid = 1'b1; iInstReqAddr = addr;
        end
        #1;
        check_output("req_ready", 64'(lsu ? oLsuReqReady : oInstReqReady), 64'd1);
        check_output("other_ready", 64'(lsu ? oInstReqReady : oLsuReqReady), 64'd0);
        if (!lsu) begin
            if (addr[1:0] != 2'b00) exp_err = 1'b1;
            else begin exp_data = ref_read(addr, 4); ref_calls++; end
        end else if (!(len == 8'd1 || len == 8'd2 || len == 8'd4 || len == 8'd8)) begin
            exp_err = 1'b1;
        end else if (we) begin
            ref_write(addr, data, int'(len)); ref_calls++;
        end else begin
            exp_data = ref_read(addr, int'(len)); ref_calls++;
        end
        rr_pref = !lsu;
        step();
        iInstReqValid = 1'b0;
        iLsuReqValid  = 1'b0;
        check_output("busy", 64'(oBusy), 64'd1);
        for (int c = 0; c < LAT; c++) begin
            check_output("resp_early", 64'(lsu ? oLsuRespValid : oInstRespValid), 64'd0);
            step();
        end
        check_output("resp_valid", 64'(lsu ? oLsuRespValid : oInstRespValid), 64'd1);
        check_output("resp_data", lsu ? oLsuRespData : 64'(oInstRespData), exp_data);
        check_output("resp_err", 64'(lsu ? oLsuRespErr : oInstRespErr), 64'(exp_err));
        check_output("dpi_calls", 64'(mem_dpi_pkg::dpi_calls), 64'(ref_calls));
        for (int h = 0; h < hold; h++) begin
            if (lsu) iInstReqValid = 1'b1; else iLsuReqValid = 1'b1;
            step();
            check_output("hold_valid", 64'(lsu ? oLsuRespValid : oInstRespValid), 64'd1);
            check_output("hold_data", lsu ? oLsuRespData : 64'(oInstRespData), exp_data);
            check_output("hold_no_accept", 64'({oInstReqReady, oLsuReqReady}), 64'd0);
        end
        iInstReqValid = 1'b0;
        iLsuReqValid  = 1'b0;
        if (lsu) iLsuRespReady = 1'b1; else iInstRespReady = 1'b1;
        step();
        iLsuRespReady  = 1'b0;
        iInstRespReady = 1'b0;
        check_output("resp_cleared", 64'(lsu ? oLsuRespValid : oInstRespValid), 64'd0);
        check_output("idle", 64'(oBusy), 64'd0);
    endtask

    // Both channels request in the same cycle. The expected winner comes from the arbitration rule.
    task automatic tie_round(input logic [63:0] addr);
        bit exp_lsu;
`ifdef MEM_DPI_RR_ARB_EN
        exp_lsu = rr_pref;
`else
        exp_lsu = 1'b1;
`endif
        iInstReqValid = 1'b1; iInstReqAddr = addr;
        iLsuReqValid = 1'b1; iLsuReqWe = 1'b0; iLsuReqAddr = addr; iLsuReqLen = 8'd4;
        #1;
        check_output("tie_lsu_ready", 64'(oLsuReqReady), 64'(exp_lsu));
        check_output("tie_inst_ready", 64'(oInstReqReady), 64'(!exp_lsu));
        iInstReqValid = 1'b0;
        iLsuReqValid  = 1'b0;
        run_txn(exp_lsu, 1'b0, addr, 64'd0, 8'd4, 0);
    endtask

    logic [7:0]  len_tab [5] = '{8'd1, 8'd2, 8'd4, 8'd8, 8'd3};
    bit          r_lsu;
    bit          r_we;
    logic [63:0] r_addr;
    logic [63:0] r_data;
    logic [7:0]  r_len;
    int          r_hold;

    initial begin
        iResetN = 1'b0; iInstReqValid = 1'b0; iInstReqAddr = '0; iInstRespReady = 1'b0;
        iLsuReqValid = 1'b0; iLsuReqWe = 1'b0; iLsuReqAddr = '0; iLsuReqData = '0;
        iLsuReqLen = '0; iLsuRespReady = 1'b0;
        #12;
        check_output("rst_inst_ready", 64'(oInstReqReady), 64'd0);
        check_output("rst_lsu_ready", 64'(oLsuReqReady), 64'd0);
        check_output("rst_inst_valid", 64'(oInstRespValid), 64'd0);
        check_output("rst_inst_data", 64'(oInstRespData), 64'd0);
        check_output("rst_inst_err", 64'(oInstRespErr), 64'd0);
        check_output("rst_lsu_valid", 64'(oLsuRespValid), 64'd0);
        check_output("rst_lsu_data", oLsuRespData, 64'd0);
        check_output("rst_lsu_err", 64'(oLsuRespErr), 64'd0);
        check_output("rst_busy", 64'(oBusy), 64'd0);
        step();
        iResetN = 1'b1;
        step();

        $display("[TB] fetch after preload store");
        run_txn(1'b1, 1'b1, 64'h8000_0000, 64'h0000_0413, 8'd4, 0);
        run_txn(1'b0, 1'b0, 64'h8000_0000, 64'd0, 8'd4, 0);

        $display("[TB] store then narrower load");
        run_txn(1'b1, 1'b1, 64'h8000_0100, 64'h1122_3344_5566_7788, 8'd8, 0);
        run_txn(1'b1, 1'b0, 64'h8000_0100, 64'd0, 8'd4, 0);

        $display("[TB] response held for five cycles");
        run_txn(1'b1, 1'b0, 64'h8000_0100, 64'd0, 8'd8, 5);

        $display("[TB] error responses");
        run_txn(1'b0, 1'b0, 64'h8000_0002, 64'd0, 8'd4, 0);
        run_txn(1'b1, 1'b0, 64'h8000_0100, 64'd0, 8'd3, 0);

        $display("[TB] reset during wait");
        iLsuReqValid = 1'b1; iLsuReqWe = 1'b0; iLsuReqAddr = 64'h8000_0100; iLsuReqLen = 8'd8;
        step();
        iLsuReqValid = 1'b0;
        #2;
        iResetN = 1'b0;
        #1;
        check_output("arst_busy", 64'(oBusy), 64'd0);
        check_output("arst_lsu_valid", 64'(oLsuRespValid), 64'd0);
        check_output("arst_lsu_data", oLsuRespData, 64'd0);
        check_output("arst_readies", 64'({oInstReqReady, oLsuReqReady}), 64'd0);
        step();
        step();
        check_output("arst_no_call", 64'(mem_dpi_pkg::dpi_calls), 64'(ref_calls));
        iResetN = 1'b1;
        rr_pref = 1'b0;
        iInstReqValid = 1'b1;
        #1;
        check_output("post_rst_inst", 64'({oLsuReqReady, oInstReqReady}), 64'b01);
        iInstReqValid = 1'b0; iLsuReqValid = 1'b1;
        #1;
        check_output("post_rst_lsu", 64'({oLsuReqReady, oInstReqReady}), 64'b10);
        iLsuReqValid = 1'b0;
        #1;
        check_output("post_rst_none", 64'({oLsuReqReady, oInstReqReady}), 64'b00);
        step();

        $display("[TB] simultaneous requests");
        for (int t = 0; t < 3; t++) tie_round(64'h8000_0100);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 24; n++) begin
            r_lsu  = 1'($urandom_range(0, 1));
            r_we   = 1'($urandom_range(0, 1));
            r_addr = 64'h8000_0100 + 64'($urandom_range(0, 23));
            if (!r_lsu && $urandom_range(0, 3) != 0) r_addr[1:0] = 2'b00;
            r_data = {$urandom, $urandom};
            r_len  = len_tab[$urandom_range(0, 4)];
            r_hold = $urandom_range(0, 3);
            run_txn(r_lsu, r_we, r_addr, r_data, r_len, r_hold);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
